// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU. The FSM runs IDLE -> EXEC -> RESP.
// Optional per-requester grant counters are built only when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             winner_q, winner_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             pick;

  // On a tie, the requester that was not granted last wins.
  assign pick = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_d       = last_q;
    gnt_d        = 2'b00;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          winner_d = pick;
          last_d   = pick;
          gnt_d    = pick ? 2'b10 : 2'b01;
          opa_d    = pick ? a1 : a0;
          opb_d    = pick ? b1 : b0;
          op_d     = pick ? op1 : op0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = RESP;
      end
      RESP: begin
        // Response handshake: the transfer completes on the rising edge where
        // rsp_valid[winner] and rsp_ready[winner] are both high; data holds until then.
        if (rsp_ready[winner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      winner_q     <= 1'b0;
      last_q       <= 1'b1;
      gnt_q        <= 2'b00;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign gnt        = gnt_q;
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_op     = op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_valid  = (state_q == RESP) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state  = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (gnt_q[0] && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
      if (gnt_q[1] && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed vectors, expected-queue scoreboard.
module tb_alu_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req, op0, op1, alu_op, gnt, rsp_valid, rsp_ready, dbg_state;
  logic [W-1:0] a0, b0, a1, b1, alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]   alu_flags, rsp_flags;
  logic [7:0]   grant_cnt0, grant_cnt1;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Shared ALU: flags are {N,Z,C,V}; subtract carry means "no borrow".
  logic [W:0] sum;
  logic       ovf;
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (alu_op)
      2'b00: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        ovf = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      2'b01: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
        ovf = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      2'b10: sum = {1'b0, alu_a & alu_b};
      default: sum = {1'b0, alu_a | alu_b};
    endcase
    alu_result = sum[W-1:0];
    alu_flags  = {sum[W-1], (sum[W-1:0] == '0), sum[W], ovf};
  end

  int n_tests = 0;
  int n_fail  = 0;
  int gnt_seen = 0;
  logic [8:0] exp_q[$];
  logic       exp_gnt_q[$];
  logic       mon_g, mon_idx;
  logic [8:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor samples mid-low-phase, after the driver has settled inputs.
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (gnt != 2'b00) begin
        check("gnt_onehot", $countones(gnt), 1);
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", {30'd0, gnt}, 0);
        else begin
          mon_g = exp_gnt_q.pop_front();
          check("gnt_id", {30'd0, gnt}, mon_g ? 32'd2 : 32'd1);
        end
        gnt_seen++;
      end
      if (rsp_valid != 2'b00) begin
        check("rsp_valid_onehot", $countones(rsp_valid), 1);
        mon_idx = rsp_valid[1];
        if (rsp_ready[mon_idx]) begin
          if (exp_q.size() == 0) check("rsp_unexpected", {23'd0, mon_idx, rsp_result, rsp_flags}, 0);
          else begin
            mon_exp = exp_q.pop_front();
            check("rsp_data", {23'd0, mon_idx, rsp_result, rsp_flags}, {23'd0, mon_exp});
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int c = 0;
    while (gnt_seen < target && c < budget) begin
      tick();
      c++;
    end
    check("grant_wait", gnt_seen, target);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || exp_gnt_q.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    check("drain", exp_q.size() + exp_gnt_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"}, {30'd0, gnt}, 0);
    check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 0);
    check({tag, "_rsp_result"}, {28'd0, rsp_result}, 0);
    check({tag, "_rsp_flags"}, {28'd0, rsp_flags}, 0);
    check({tag, "_alu_a"}, {28'd0, alu_a}, 0);
    check({tag, "_alu_b"}, {28'd0, alu_b}, 0);
    check({tag, "_alu_op"}, {30'd0, alu_op}, 0);
    check({tag, "_state"}, {30'd0, dbg_state}, 0);
  endtask

  initial begin
    int base;
    logic [7:0] exp_cnt0;
    rst_n = 1'b0; req = 2'b00; rsp_ready = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = 2'b00; op1 = 2'b00;
    repeat (2) tick();
    check_zero_outputs("reset");
    check("reset_cnt0", {24'd0, grant_cnt0}, 0);
    rst_n = 1'b1;
    tick();

    // Tie and rotation: 0,1,0,1.
    a0 = 4'd1; b0 = 4'd2; op0 = 2'b10;
    a1 = 4'd6; b1 = 4'd3; op1 = 2'b11;
    rsp_ready = 2'b11; req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_gnt_q.push_back(1'b0); exp_q.push_back({1'b0, 4'd0, 4'b0100});
      exp_gnt_q.push_back(1'b1); exp_q.push_back({1'b1, 4'd7, 4'b0000});
    end
    base = gnt_seen;
    wait_grants(base + 4, 40);
    req = 2'b00;
    drain(20);

    // Single request with latency checks; operand change after grant is ignored.
    a0 = 4'd3; b0 = 4'd4; op0 = 2'b00; rsp_ready = 2'b01; req = 2'b01;
    exp_gnt_q.push_back(1'b0); exp_q.push_back({1'b0, 4'd7, 4'b0000});
    tick();
    check("t1_gnt", {30'd0, gnt}, 1);
    check("t1_alu_a", {28'd0, alu_a}, 3);
    check("t1_alu_b", {28'd0, alu_b}, 4);
    req = 2'b00; a0 = 4'd9;
    tick();
    check("t1_latency", {30'd0, rsp_valid}, 1);
    drain(10);
    check("t1_alu_hold", {28'd0, alu_a}, 3);

    // Subtract to zero under backpressure; stray req and non-winner ready are ignored.
    a1 = 4'd5; b1 = 4'd5; op1 = 2'b01; rsp_ready = 2'b00; req = 2'b10;
    exp_gnt_q.push_back(1'b1); exp_q.push_back({1'b1, 4'd0, 4'b0110});
    tick();
    check("t3_gnt", {30'd0, gnt}, 2);
    req = 2'b00; a1 = 4'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_valid_hold", {30'd0, rsp_valid}, 2);
      check("t3_result_hold", {28'd0, rsp_result}, 0);
      check("t3_flags_hold", {28'd0, rsp_flags}, 32'h6);
      check("t3_no_gnt", {30'd0, gnt}, 0);
      req = 2'b01; rsp_ready = 2'b01;
      tick();
    end
    req = 2'b00; rsp_ready = 2'b10;
    tick();
    check("t3_released", {30'd0, rsp_valid}, 0);
    check("t3_idle", {30'd0, dbg_state}, 0);
    drain(5);

    // Reset during EXEC discards the transaction and restores the tie pointer.
    a0 = 4'd8; b0 = 4'd9; op0 = 2'b00; rsp_ready = 2'b11; req = 2'b11;
    tick();
    check("t4_gnt", {30'd0, gnt}, 1);
    req = 2'b00;
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("t4_async");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_rsp", {30'd0, rsp_valid}, 0);
    end
    req = 2'b11;
    exp_gnt_q.push_back(1'b0); exp_q.push_back({1'b0, 4'd1, 4'b0011});
    tick();
    check("t4_tie_after_reset", {30'd0, gnt}, 1);
    req = 2'b00;
    drain(10);

    // 300 grants to requester 0.
    a0 = 4'd3; b0 = 4'd4; op0 = 2'b00; rsp_ready = 2'b01; req = 2'b01;
    for (int i = 0; i < 300; i++) begin
      exp_gnt_q.push_back(1'b0); exp_q.push_back({1'b0, 4'd7, 4'b0000});
    end
    base = gnt_seen;
    wait_grants(base + 300, 1200);
    req = 2'b00;
    drain(10);
`ifdef ALU_ARB_STATS_EN
    exp_cnt0 = 8'd255;
`else
    exp_cnt0 = 8'd0;
`endif
    check("stats_cnt0", {24'd0, grant_cnt0}, {24'd0, exp_cnt0});
    check("stats_cnt1", {24'd0, grant_cnt1}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
